// File: rtl/count_arbiter_if.sv
// Handshake bundle between the two interval requesters and count_arbiter.
// master = requester side, slave = arbiter side.
interface count_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] count;

    modport master (output req, len0, len1, input gnt, done, busy, count);
    modport slave  (input req, len0, len1, output gnt, done, busy, count);
endinterface

// File: rtl/count_arbiter.sv
// Shares one interval counter between two requesters: grant, load, count, done.
// Define RR_PRIORITY_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module count_arbiter #(
    parameter int WIDTH = 4
) (
    input logic            clk,
    input logic            reset,
    count_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    state_t           state;
    logic             win;
    logic [WIDTH-1:0] len_lat;
    logic             pick;
    logic             tie;

`ifdef RR_PRIORITY_EN
    logic ptr;
    assign tie = ptr;
`else
    assign tie = 1'b0;
`endif

    always_comb begin
        pick = bus.req[1];
        if (&bus.req) pick = tie;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            win       <= 1'b0;
            len_lat   <= '0;
            bus.gnt   <= '0;
            bus.done  <= '0;
            bus.busy  <= 1'b0;
            bus.count <= '0;
`ifdef RR_PRIORITY_EN
            ptr       <= 1'b0;
`endif
        end else begin
            bus.done <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        win      <= pick;
                        bus.gnt  <= pick ? 2'b10 : 2'b01;
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD, COUNT: begin
                    // Abort has precedence over both the load and the terminal compare.
                    if (!bus.req[win]) begin
                        state    <= IDLE;
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
`ifdef RR_PRIORITY_EN
                        ptr      <= ~win;
`endif
                    end else if (state == LOAD) begin
                        bus.count <= '0;
                        len_lat   <= win ? bus.len1 : bus.len0;
                        state     <= COUNT;
                    end else if (bus.count == len_lat) begin
                        bus.done[win] <= 1'b1;
                        bus.gnt       <= '0;
                        state         <= DONE;
                    end else begin
                        bus.count <= bus.count + 1'b1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
`ifdef RR_PRIORITY_EN
                    ptr      <= ~win;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/count_arbiter.md
# count_arbiter

Controller that shares one WIDTH-bit interval counter between two requesters. Each requester asks for a delay of `len` ticks. The arbiter grants the counter to one requester at a time, then clears it, runs it up to the latched length, and pulses a per-requester `done`. It sits between the counter datapath and the two blocks that need timed intervals, and replaces free-running ripple counting with a sequenced, synchronous count.

## Interface
- WIDTH, 4, width of the counter and of each length request
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; takes effect on the next rising edge of clk
- req  input  2  req[i] high = requester i wants the counter; held until done[i] or abort
- len0  input  WIDTH  requested terminal count for requester 0; sampled in LOAD only
- len1  input  WIDTH  requested terminal count for requester 1; sampled in LOAD only
- gnt  output  2  one-hot (or zero) grant, registered
- done  output  2  one-cycle completion pulse to the granted requester
- busy  output  1  high in every state except IDLE
- count  output  WIDTH  current counter value

## Operation
- States: IDLE, LOAD, COUNT, DONE. Reset state is IDLE.
- Reset values: gnt=0, done=0, busy=0, count=0, priority pointer=0.
- **IDLE**
  - If req==0, stay in IDLE.
  - Otherwise pick a winner w. With a single request, that requester wins. With both requesting, requester `ptr` wins.
  - Set gnt[w]=1, latch w, and go to LOAD.
- **LOAD**
  - count←0; len_lat←len_w; go to COUNT.
  - gnt[w] stays high.
- **COUNT**
  - If count==len_lat, go to DONE with count held.
  - Otherwise count←count+1.
  - count never wraps, because len_lat ≤ 2^WIDTH−1.
  - len_lat=0 gives one COUNT cycle. len_lat=2^WIDTH−1 gives 2^WIDTH COUNT cycles.
- **DONE**
  - done[w]=1 for exactly this cycle; gnt=0.
  - ptr←~w (round-robin, see Configuration).
  - Go to IDLE. count holds its final value until the next LOAD.
- **Abort:** req[w] low while in LOAD or COUNT sends the FSM to IDLE on the next edge.
  - gnt←0, no done pulse, count holds.
  - ptr←~w.
- The non-granted requester's req is ignored until the FSM is back in IDLE. There is no preemption.
- **Reset mid-operation:** on the next edge, return to IDLE with all outputs at their reset values. No done pulse is issued.
- A req still high in DONE is treated as a new request in the following IDLE cycle.

## Timing
- req sampled at edge E (FSM in IDLE):
  - gnt high after E.
  - LOAD during cycle E..E+1.
  - count=0 after E+1.
  - count=k after E+1+k.
  - done high after E+2+len.
  - busy low again after E+3+len.
- Request-to-done latency: len+2 edges. Back-to-back grant turnaround: 2 cycles (DONE, IDLE).
- A minimum-throughput transaction (len=0) occupies 4 cycles: IDLE, LOAD, COUNT, DONE.
- All outputs are registered. There is no combinational path from req or len to any output.

## Configuration
- RR_PRIORITY_EN defined: round-robin.
  - Ties go to requester `ptr`.
  - ptr toggles to the other requester after every DONE or abort.
- RR_PRIORITY_EN undefined: fixed priority.
  - Requester 0 always wins ties.
  - ptr logic is removed.
  - All other behaviour is identical.

## Test plan
- **Reset:** assert reset for 2 cycles with req=2'b11 -> gnt=0, done=0, busy=0, count=0. The first grant after release goes to requester 0.
- **Single request:** req=2'b01, len0=5 -> gnt=01 for 7 cycles, count steps 0..5, done=01 for one cycle at len+2 edges after the sample, busy drops the next cycle.
- **Contention:** req=2'b11 held, len0=3, len1=2, RR_PRIORITY_EN defined -> grant order 0,1,0,1 with done pulses alternating. Without the macro -> requester 0 is granted every time and requester 1 starves.
- **Boundaries:**
  - len1=0 -> exactly one COUNT cycle, count=0, done=10.
  - len0=15 (WIDTH=4) -> 16 COUNT cycles, count ends at 15, no wrap to 0.
- **Abort:** req[0] dropped when count=2 with len0=9 -> next edge gnt=0, no done, count holds 2, FSM in IDLE. A pending req[1] is granted next cycle.
- **Reset mid-count:** reset pulsed at count=4 -> next edge everything is 0, done never pulses. A held req restarts from LOAD after reset is released.
